// File: rtl/data_hamm_pkg.sv
// Shared constants and syndrome table for the 20-bit data Hamming decoder.
// Parity masks, syndrome lookup and the s=21 ambiguity marker live here.
package data_hamm_pkg;

  localparam int DATA_W = 20;
  localparam int CHK_W  = 5;
  localparam int WORD_W = DATA_W + CHK_W;

  localparam logic [19:0] PAR_M0 = 20'hAAD5B;
  localparam logic [19:0] PAR_M1 = 20'h1366D;
  localparam logic [19:0] PAR_M2 = 20'h3C78E;
  localparam logic [19:0] PAR_M3 = 20'hC07F0;
  localparam logic [19:0] PAR_M4 = 20'hFF800;

  localparam logic [4:0][19:0] PAR_MASK =
    {PAR_M4, PAR_M3, PAR_M2, PAR_M1, PAR_M0};

  // d15 and d17 both produce this syndrome
  localparam logic [4:0] SYN_AMBIG = 5'd21;

  typedef enum logic [1:0] {
    SK_NONE,
    SK_CHK,
    SK_DATA,
    SK_BAD
  } syn_kind_e;

  typedef struct packed {
    syn_kind_e  kind;
    logic [4:0] pos;
  } syn_info_t;

  function automatic syn_info_t syn_lookup(
    input logic [4:0] s
  );
    syn_info_t r;
    r.kind = SK_DATA;
    r.pos  = 5'd0;
    case (s)
      5'd0:  r.kind = SK_NONE;
      5'd1,
      5'd2,
      5'd4,
      5'd8,
      5'd16: r.kind = SK_CHK;
      5'd3:  r.pos = 5'd0;
      5'd5:  r.pos = 5'd1;
      5'd6:  r.pos = 5'd2;
      5'd7:  r.pos = 5'd3;
      5'd9:  r.pos = 5'd4;
      5'd10: r.pos = 5'd5;
      5'd11: r.pos = 5'd6;
      5'd12: r.pos = 5'd7;
      5'd13: r.pos = 5'd8;
      5'd14: r.pos = 5'd9;
      5'd15: r.pos = 5'd10;
      5'd17: r.pos = 5'd11;
      5'd18: r.pos = 5'd12;
      5'd19: r.pos = 5'd13;
      5'd20: r.pos = 5'd14;
      5'd22: r.pos = 5'd16;
      5'd24: r.pos = 5'd18;
      5'd25: r.pos = 5'd19;
      SYN_AMBIG: r.kind = SK_BAD;
      default:   r.kind = SK_BAD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_hamm_syn.sv
// Syndrome generator: recomputed parity XOR received check bits.
// Purely combinational.
module data_hamm_syn
  import data_hamm_pkg::*;
(
  input  logic [24:0] word,
  output logic [4:0]  syn
);

  // one XOR reduction per check bit
  always_comb begin
    syn = '0;
    for (int i = 0; i < CHK_W; i++) begin
      syn[i] = (^(word[19:0] & PAR_MASK[i]))
             ^ word[DATA_W + i];
    end
  end

endmodule

// File: rtl/data_hamm_dec.sv
// Two-stage SEC decoder for 20-bit data with 5 check bits.
// Valid/ready on both sides, saturating corrected/error counters.
module data_hamm_dec
  import data_hamm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [24:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      out_data,
  output logic             out_corr,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        s1_valid;
  logic [19:0] s1_data;
  logic [4:0]  s1_syn;
  logic [4:0]  syn_in;
  logic        ld1;
  logic        ld2;
  logic        xfer;
  syn_info_t   info;
  logic [19:0] fix_mask;
  logic [19:0] nxt_data;
  logic        nxt_corr;
  logic        nxt_err;

  data_hamm_syn u_syn (
    .word (in_data),
    .syn  (syn_in)
  );

  assign ld2      = !out_valid || out_ready;
  assign ld1      = !s1_valid || ld2;
  assign in_ready = ld1;
  assign xfer     = out_valid && out_ready;

  // classify the stage-1 syndrome and build the corrected word
  always_comb begin
    info     = syn_lookup(s1_syn);
    fix_mask = '0;
    nxt_corr = 1'b0;
    nxt_err  = 1'b0;
    unique case (1'b1)
      (info.kind == SK_DATA): begin
        fix_mask = 20'd1 << info.pos;
        nxt_corr = 1'b1;
      end
      (info.kind == SK_CHK): nxt_corr = 1'b1;
      (info.kind == SK_BAD): nxt_err  = 1'b1;
      default: ;
    endcase
    nxt_data = s1_data ^ fix_mask;
  end

  // stage 1: raw data plus syndrome
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
    end else if (ld1) begin
      s1_valid <= in_valid;
      s1_data  <= in_data[19:0];
      s1_syn   <= syn_in;
    end
  end

  // stage 2: corrected output, held while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_corr  <= 1'b0;
      out_err   <= 1'b0;
    end else if (ld2) begin
      out_valid <= s1_valid;
      out_data  <= nxt_data;
      out_corr  <= nxt_corr;
      out_err   <= nxt_err;
    end
  end

  // saturating counters; clear beats increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      corr_cnt <= '0;
      err_cnt  <= '0;
    end else if (xfer) begin
      if (out_corr && corr_cnt != CNT_MAX)
        corr_cnt <= corr_cnt + 1'b1;
      if (out_err && err_cnt != CNT_MAX)
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
